pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: DEPTH, 2, fetch-queue entries; legal range 2..4.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: fetch_en  input  1  1 = fetch permitted; 0 = PC and queue pushes frozen.
REQ-006 Port: redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 Port: redirect_target  input  32  byte address of the new PC.
REQ-008 Port: imem_pc  output  32  address to the instruction memory; equals pc_q combinationally.
REQ-009 Port: imem_instr  input  32  instruction returned by the instruction memory in the same cycle (zero latency).
REQ-010 Port: out_valid  output  1  queue head holds a valid entry.
REQ-011 Port: out_ready  input  1  decode stage accepts the head this cycle.
REQ-012 Port: out_pc  output  32  PC of the head entry.
REQ-013 Port: out_instr  output  32  instruction of the head entry.
REQ-014 Port: misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Function
REQ-015 pc_q SHALL drive imem_pc directly, with no added latency.
REQ-016 Push condition SHALL be: fetch_en=1, misalign_err=0, redirect_valid=0, and (count<DEPTH or pop this cycle).
REQ-017 On push, {pc_q, imem_instr} SHALL be written to the tail and pc_q SHALL become pc_q+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-018 Pop SHALL occur when out_valid=1 and out_ready=1, removing the head at the clock edge.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-020 out_valid SHALL equal (count != 0); out_pc and out_instr SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Redirect with target[1:0]==0 SHALL take priority: pc_q <= target, queue flushed (count=0), and no push that cycle.
REQ-022 Redirect with target[1:0]!=0 SHALL flush the queue, leave pc_q unchanged, and set misalign_err; pushes then stop.
REQ-023 misalign_err SHALL be cleared only by reset or by a later aligned redirect, which is handled as in REQ-021.
REQ-024 A pop coinciding with a redirect SHALL complete; the consumer owns that entry, and all remaining entries are discarded.
REQ-025 Latency: redirect sampled at edge N gives first push at edge N+1, so out_valid=1 with out_pc=target after edge N+1.
REQ-026 fetch_en=0 SHALL hold pc_q; pops and redirects remain active.
REQ-027 Out-of-range addresses are not checked here; the returned instruction word is queued as is.

Reset
REQ-028 While rst_n=0: pc_q=RESET_PC, count=0, read/write pointers=0, misalign_err=0, out_valid=0.
REQ-029 While rst_n=0: out_pc=0 and out_instr=32'h0000_0013 (NOP); queue storage contents are don't-care.
REQ-030 Reset assertion SHALL take effect immediately, mid-operation included; first push is at the first edge after release with fetch_en=1.

Structure
REQ-031 A shared package SHALL hold the constants INSTR_NOP=32'h0000_0013, PC_STEP=4 and the {pc, instr} entry record type.
REQ-032 The queue SHALL be a sub-module fetch_fifo (parameter DEPTH, flush input, push/pop, count) instantiated once.
REQ-033 Target size is 120-400 RTL lines; there are no latches, and all sequential logic is in clk/rst_n-sensitive processes.

Verification
REQ-034 Reset release, fetch_en=1, out_ready=1, memory preloaded with fe010113, 00112e23, 00812c23 -> out_pc 0, 4, 8 on consecutive cycles with matching instructions.
REQ-035 out_ready=0 for 5 cycles -> queue fills to DEPTH, pc_q holds at 8, and head stays out_pc=0 / out_instr=fe010113 throughout.
REQ-036 Redirect to 32'h0000_004C while full and popping -> popped entry delivered, queue flushed, next out_pc=0x4C carrying memory[19]=fe010113 after one bubble.
REQ-037 Redirect to 32'h0000_0026 -> misalign_err=1, out_valid=0 thereafter; then aligned redirect to 0x0 -> misalign_err=0 and fetch resumes at 0.
REQ-038 pc_q at 32'hFFFF_FFFC with a push -> next pc_q=0 and no X propagation.
REQ-039 rst_n asserted mid-stream with 2 entries queued -> out_valid=0 immediately; after release, out_pc restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit.
//   INSTR_NOP     : instruction word presented when no entry is queued
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one fetch-queue record {pc, instr}
package pc_fetch_unit_pkg;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Word-aligned byte address check.
   function automatic logic is_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch queue.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : discard every entry (wins over push in the same cycle)
//   push_i        : write wdata_i at the tail
//   pop_i         : drop the head (ignored when empty)
//   rdata_o       : head entry; {0, INSTR_NOP} while empty
//   count_o       : number of valid entries
module fetch_fifo
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            push_i,
   input  fetch_entry_t    wdata_i,
   input  logic            pop_i,
   output fetch_entry_t    rdata_o,
   output logic [CntW-1:0] count_o
);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            empty, full;
   logic            pop_ok, push_ok;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign pop_ok  = pop_i & ~empty;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign push_ok = push_i & (~full | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is cleared on reset only to keep X out of simulation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '{pc: 32'h0, instr: INSTR_NOP};
      if (!empty) rdata_o = mem_q[rd_ptr_q];
   end

   assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: program counter, zero-latency memory request,
// and a fetch queue feeding decode with a valid/ready handshake.
//   clk, rst_n       : clock, asynchronous active-low reset
//   fetch_en         : allow PC advance and queue pushes
//   redirect_valid   : taken branch/jump; redirect_target is the new PC
//   imem_pc          : instruction memory address (= pc_q)
//   imem_instr       : instruction returned in the same cycle
//   out_valid/ready  : head handshake, out_pc/out_instr carry the head
//   misalign_err     : sticky, set by a redirect to a non-word address
// DEPTH must be within 2..4.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        misalign_err
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [31:0]     pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic            push, pop, flush, full;
   logic [CntW-1:0] count;
   fetch_entry_t    wentry, head;

   assign full      = (count == CntW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign wentry    = '{pc: pc_q, instr: imem_instr};

   // Redirect outranks fetching. A same-cycle pop still hands its entry to
   // the consumer; the flush discards only what remains behind it.
   always_comb begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      push       = 1'b0;
      flush      = redirect_valid;
      if (redirect_valid) begin
         if (is_aligned(redirect_target)) begin
            pc_d       = redirect_target;
            misalign_d = 1'b0;
         end else begin
            misalign_d = 1'b1;
         end
      end else if (fetch_en && !misalign_q && (!full || pop)) begin
         push = 1'b1;
         pc_d = pc_q + PC_STEP;  // wraps naturally at 2^32
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (wentry),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count)
   );

   assign imem_pc      = pc_q;
   assign out_pc       = head.pc;
   assign out_instr    = head.instr;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        misalign_err;

   logic [31:0] mem [64];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_pc[7:2]];

   pc_fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_en        (fetch_en),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_pc         (imem_pc),
      .imem_instr      (imem_instr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .misalign_err    (misalign_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of {pc, instr} plus a PC and an error bit.
   logic [63:0] m_q [$];
   logic [31:0] m_pc;
   logic        m_mis;
   bit          m_pop;
   bit          m_push;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_pc  = RESET_PC;
         m_mis = 1'b0;
      end else begin
         m_pop = (m_q.size() != 0) && out_ready;
         if (redirect_valid) begin
            m_q.delete();
            if (redirect_target[1:0] == 2'b00) begin
               m_pc  = redirect_target;
               m_mis = 1'b0;
            end else begin
               m_mis = 1'b1;
            end
         end else begin
            m_push = fetch_en && !m_mis && ((m_q.size() < DEPTH) || m_pop);
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
               m_q.push_back({m_pc, mem[m_pc[7:2]]});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_imem_pc", imem_pc, m_pc);
         check("cmp_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         check("cmp_misalign", 32'(misalign_err), 32'(m_mis));
         if (m_q.size() != 0) begin
            check("cmp_out_pc", out_pc, m_q[0][63:32]);
            check("cmp_out_instr", out_instr, m_q[0][31:0]);
         end
      end
   end

   // Returns 2 time units after the next rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n           = 1'b0;
      fetch_en        = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      out_ready       = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[0]  = 32'hfe01_0113;
      mem[1]  = 32'h0011_2e23;
      mem[2]  = 32'h0081_2c23;
      mem[19] = 32'hfe01_0113;

      // Reset values
      #3;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, NOP);
      check("rst_imem_pc", imem_pc, RESET_PC);
      check("rst_misalign", 32'(misalign_err), 32'h0);
      step(2);

      // Streaming fetch with decode always ready
      rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
      step(1);
      check("s_pc0", out_pc, 32'h0);
      check("s_in0", out_instr, 32'hfe01_0113);
      step(1);
      check("s_pc1", out_pc, 32'h4);
      check("s_in1", out_instr, 32'h0011_2e23);
      step(1);
      check("s_pc2", out_pc, 32'h8);
      check("s_in2", out_instr, 32'h0081_2c23);

      // Back-pressure from reset: queue fills, PC and head hold
      rst_n = 1'b0; out_ready = 1'b0;
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("bp_out_pc", out_pc, 32'h0);
         check("bp_out_instr", out_instr, 32'hfe01_0113);
         check("bp_valid", 32'(out_valid), 32'h1);
         if (i >= 1) check("bp_imem_pc", imem_pc, 32'h8);
      end

      // Redirect while full and popping
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_004C;
      #1;
      check("rd_deliver_pc", out_pc, 32'h0);
      check("rd_deliver_valid", 32'(out_valid), 32'h1);
      step(1);
      redirect_valid = 1'b0;
      check("rd_bubble", 32'(out_valid), 32'h0);
      check("rd_imem_pc", imem_pc, 32'h0000_004C);
      step(1);
      check("rd_valid", 32'(out_valid), 32'h1);
      check("rd_out_pc", out_pc, 32'h0000_004C);
      check("rd_out_instr", out_instr, 32'hfe01_0113);

      // Misaligned redirect, then recovery via an aligned one
      redirect_valid = 1'b1; redirect_target = 32'h0000_0026;
      step(1);
      redirect_valid = 1'b0;
      check("mis_flag", 32'(misalign_err), 32'h1);
      check("mis_valid", 32'(out_valid), 32'h0);
      check("mis_pc_hold", imem_pc, 32'h0000_0050);
      step(3);
      check("mis_flag_sticky", 32'(misalign_err), 32'h1);
      check("mis_valid_stays", 32'(out_valid), 32'h0);
      redirect_valid = 1'b1; redirect_target = 32'h0;
      step(1);
      redirect_valid = 1'b0;
      check("fix_flag", 32'(misalign_err), 32'h0);
      check("fix_imem_pc", imem_pc, 32'h0);
      step(1);
      check("fix_out_pc", out_pc, 32'h0);
      check("fix_valid", 32'(out_valid), 32'h1);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step(1);
      redirect_valid = 1'b0;
      check("wrap_pre", imem_pc, 32'hFFFF_FFFC);
      step(1);
      check("wrap_pc", imem_pc, 32'h0);
      check("wrap_known", 32'($isunknown(imem_pc)), 32'h0);
      check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
      check("wrap_out_instr", out_instr, 32'h1000_003F);

      // Asynchronous reset with entries queued
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0010;
      step(1);
      redirect_valid = 1'b0;
      step(2);
      check("ar_pre_pc", out_pc, 32'h0000_0010);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(out_valid), 32'h0);
      check("ar_out_pc", out_pc, 32'h0);
      check("ar_out_instr", out_instr, NOP);
      check("ar_imem_pc", imem_pc, RESET_PC);
      step(1);
      rst_n = 1'b1; out_ready = 1'b1;
      step(1);
      check("ar_restart_pc", out_pc, RESET_PC);
      check("ar_restart_valid", 32'(out_valid), 32'h1);
      step(3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
